// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared defaults and frame-length constants for the DMA stream path
package dma_pkg;

    localparam int DMA_DW         = 32;
    localparam int DMA_FIFO_DEPTH = 8;
    localparam int DMA_LENW       = 6;

    // Frame lengths the sequencer programs into frame_len_i
    localparam int FIR_TAPS = 11;
    localparam int FIR_DATA = 64;
    localparam int MM_LEN   = 32;

endpackage

// File: rtl/dma_stream_fifo.sv
// rtl/dma_stream_fifo.sv - elastic stream buffer between DMA and accelerator with frame tlast generation
module dma_stream_fifo
    import dma_pkg::*;
#(
    parameter int DW    = DMA_DW,
    parameter int DEPTH = DMA_FIFO_DEPTH,
    parameter int LENW  = DMA_LENW
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     flush_i,
    input  logic [LENW-1:0]          frame_len_i,
    input  logic [DW-1:0]            s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DW-1:0]            m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     frame_done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [LENW-1:0] beat_cnt;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            last_beat;

    // Extra wrap bit on the pointers distinguishes full from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Ready never looks at m_tready, so a full buffer cannot accept on the pop cycle
    assign s_tready = wb_rst_n_i && !full && !flush_i;
    assign m_tvalid = !empty;
    assign m_tdata  = mem[rd_ptr[AW-1:0]];
    assign level_o  = wr_ptr - rd_ptr;

    assign push = s_tvalid && s_tready;
    assign pop  = m_tvalid && m_tready && !flush_i;

    assign last_beat = (frame_len_i != '0) && (beat_cnt == frame_len_i - LEN_ONE);
    assign m_tlast   = m_tvalid && last_beat;

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_tdata;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A length of zero parks the counter so tlast never fires
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            beat_cnt     <= '0;
            frame_done_o <= 1'b0;
        end else if (flush_i) begin
            beat_cnt     <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= pop && m_tlast;
            if (frame_len_i == '0) begin
                beat_cnt <= '0;
            end else if (pop) begin
                beat_cnt <= m_tlast ? '0 : beat_cnt + LEN_ONE;
            end
        end
    end

endmodule

// File: tb/tb_dma_stream_fifo.sv
// tb/tb_dma_stream_fifo.sv - randomized self-checking bench for dma_stream_fifo
module tb_dma_stream_fifo;
    import dma_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LENW  = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [LENW-1:0] frame_len;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [3:0]      level;
    logic            frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    dma_stream_fifo #(.DW(DW), .DEPTH(DEPTH), .LENW(LENW)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .flush_i      (flush),
        .frame_len_i  (frame_len),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .level_o      (level),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        #1;
        n_tests++;
        if (level !== 4'd0 || m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tlast !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: level=%0d m_tvalid=%b s_tready=%b m_tlast=%b done=%b expected 0 0 0 0 0",
                     level, m_tvalid, s_tready, m_tlast, frame_done);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: s_tready=%b expected 1", s_tready);
        end
        tick();
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hA0 + i;
            tick();
        end
        s_tvalid = 1'b0;
        #1;
        n_tests++;
        if (level !== 4'd5 || m_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prefill: level=%0d m_tvalid=%b expected 5 1", level, m_tvalid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (level !== 4'd0 || m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: level=%0d m_tvalid=%b s_tready=%b expected 0 0 0", level, m_tvalid, s_tready);
        end
        tick();
        rst_n    = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (m_tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_stale: cycle %0d m_tvalid=%b expected 0", i, m_tvalid);
            end
            tick();
        end
    endtask

    task automatic test_fill_full();
        logic pushed;
        frame_len = '0;
        m_tready  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h100 + i;
            #1;
            n_tests++;
            if (s_tready !== (i < DEPTH) || level !== 4'(i)) begin
                n_fail++;
                $display("FAIL fill_ready: push %0d s_tready=%b level=%0d expected %b %0d", i, s_tready, level, i < DEPTH, i);
            end
            if (i < DEPTH) tick();
        end
        n_tests++;
        if (level !== 4'd8 || s_tdata !== 32'h108) begin
            n_fail++;
            $display("FAIL fill_full_level: level=%0d expected 8", level);
        end
        tick();
        m_tready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            n_tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'h100 + k || m_tlast !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_order: beat %0d m_tvalid=%b m_tdata=%h m_tlast=%b expected 1 %h 0",
                         k, m_tvalid, m_tdata, m_tlast, 32'h100 + k);
            end
            if (k == 0) begin
                n_tests++;
                if (s_tready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_no_bypass: s_tready=%b expected 0 on pop cycle when full", s_tready);
                end
            end
            pushed = s_tvalid && s_tready;
            tick();
            if (pushed) s_tvalid = 1'b0;
        end
        #1;
        n_tests++;
        if (m_tvalid !== 1'b0 || level !== 4'd0) begin
            n_fail++;
            $display("FAIL drain_empty: m_tvalid=%b level=%0d expected 0 0", m_tvalid, level);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        frame_len = '0;
        m_tready  = 1'b1;
        for (int cyc = 0; cyc < 100 && got < FIR_DATA; cyc++) begin
            s_tvalid = (sent < FIR_DATA);
            s_tdata  = sent + 1;
            #1;
            if (cyc == 0) begin
                n_tests++;
                if (m_tvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_latency0: m_tvalid=%b expected 0 in push cycle", m_tvalid);
                end
            end
            if (cyc == 1) begin
                n_tests++;
                if (m_tvalid !== 1'b1 || m_tdata !== 32'd1) begin
                    n_fail++;
                    $display("FAIL stream_latency1: m_tvalid=%b m_tdata=%h expected 1 1", m_tvalid, m_tdata);
                end
            end
            if (cyc >= 1 && level > 4'd1) begin
                n_tests++;
                n_fail++;
                $display("FAIL stream_level: cycle %0d level=%0d expected <=1", cyc, level);
            end
            if (m_tvalid && m_tready) begin
                got++;
                if (m_tdata !== 32'(got)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_data: beat %0d m_tdata=%h expected %h", got, m_tdata, got);
                end
            end
            if (s_tvalid && s_tready) sent++;
            tick();
        end
        s_tvalid = 1'b0;
        n_tests++;
        if (got != FIR_DATA) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected %0d", got, FIR_DATA);
        end
    endtask

    task automatic test_frame_tlast();
        int sent = 0;
        int pops = 0;
        int lasts = 0;
        logic exp_done = 1'b0;
        logic exp_last;
        frame_len = LENW'(FIR_TAPS);
        m_tready  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            s_tvalid = (sent < 2 * FIR_TAPS);
            s_tdata  = 32'h500 + sent;
            #1;
            n_tests++;
            if (frame_done !== exp_done) begin
                n_fail++;
                $display("FAIL frame_done: cycle %0d frame_done=%b expected %b", cyc, frame_done, exp_done);
            end
            exp_done = 1'b0;
            if (m_tvalid) begin
                exp_last = ((pops + 1) % FIR_TAPS) == 0;
                n_tests++;
                if (m_tlast !== exp_last || m_tdata !== 32'h500 + pops) begin
                    n_fail++;
                    $display("FAIL frame_tlast: beat %0d m_tlast=%b m_tdata=%h expected %b %h",
                             pops + 1, m_tlast, m_tdata, exp_last, 32'h500 + pops);
                end
                pops++;
                if (exp_last) lasts++;
                exp_done = exp_last;
            end
            if (s_tvalid && s_tready) sent++;
            tick();
        end
        s_tvalid = 1'b0;
        n_tests++;
        if (pops != 2 * FIR_TAPS || lasts != 2) begin
            n_fail++;
            $display("FAIL frame_count: pops=%0d lasts=%0d expected %0d 2", pops, lasts, 2 * FIR_TAPS);
        end
    endtask

    task automatic test_len_one();
        frame_len = LENW'(1);
        m_tready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h700 + i;
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (i < 3 && (m_tlast !== 1'b1 || m_tdata !== 32'h700 + i)) begin
                n_fail++;
                $display("FAIL len1_tlast: beat %0d m_tlast=%b m_tdata=%h expected 1 %h", i, m_tlast, m_tdata, 32'h700 + i);
            end
            if (frame_done !== (i > 0)) begin
                n_fail++;
                $display("FAIL len1_done: cycle %0d frame_done=%b expected %b", i, frame_done, i > 0);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        int pops = 0;
        int sent = 0;
        logic exp_last;
        frame_len = LENW'(FIR_TAPS);
        m_tready  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h200 + i;
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) tick();
        m_tready = 1'b0;
        #1;
        n_tests++;
        if (level !== 4'd4 || m_tlast !== 1'b0 || m_tdata !== 32'h203) begin
            n_fail++;
            $display("FAIL flush_pre: level=%0d m_tlast=%b m_tdata=%h expected 4 0 203", level, m_tlast, m_tdata);
        end
        tick();
        flush    = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD;
        m_tready = 1'b1;
        #1;
        n_tests++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: s_tready=%b expected 0", s_tready);
        end
        tick();
        flush    = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #1;
        n_tests++;
        if (level !== 4'd0 || m_tvalid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: level=%0d m_tvalid=%b frame_done=%b expected 0 0 0", level, m_tvalid, frame_done);
        end
        tick();
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            s_tvalid = (sent < FIR_TAPS);
            s_tdata  = 32'h300 + sent;
            #1;
            if (m_tvalid) begin
                exp_last = (pops + 1) == FIR_TAPS;
                n_tests++;
                if (m_tlast !== exp_last || m_tdata !== 32'h300 + pops) begin
                    n_fail++;
                    $display("FAIL flush_frame: beat %0d m_tlast=%b m_tdata=%h expected %b %h",
                             pops + 1, m_tlast, m_tdata, exp_last, 32'h300 + pops);
                end
                pops++;
            end
            if (s_tvalid && s_tready) sent++;
            tick();
        end
        s_tvalid = 1'b0;
        n_tests++;
        if (pops != FIR_TAPS) begin
            n_fail++;
            $display("FAIL flush_frame_count: pops=%0d expected %0d", pops, FIR_TAPS);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        int pops = 0;
        int lasts = 0;
        int cyc = 0;
        logic exp_done = 1'b0;
        logic exp_last;
        logic stalled = 1'b0;
        logic [DW-1:0] held = '0;
        logic do_pop;
        logic do_push;
        frame_len = LENW'(MM_LEN);
        while (pops < 1000 && cyc < 6000) begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            m_tready = 1'($urandom_range(0, 1));
            #1;
            exp_last = (q.size() != 0) && ((pops % MM_LEN) == MM_LEN - 1);
            n_tests++;
            if (level !== 4'(q.size()) || m_tvalid !== (q.size() != 0) || s_tready !== (q.size() < DEPTH)
                || frame_done !== exp_done) begin
                n_fail++;
                $display("FAIL rand_ctrl: cycle %0d level=%0d m_tvalid=%b s_tready=%b done=%b expected %0d %b %b %b",
                         cyc, level, m_tvalid, s_tready, frame_done, q.size(), q.size() != 0, q.size() < DEPTH, exp_done);
            end
            if (q.size() != 0) begin
                n_tests++;
                if (m_tdata !== q[0] || m_tlast !== exp_last || (stalled && m_tdata !== held)) begin
                    n_fail++;
                    $display("FAIL rand_data: cycle %0d m_tdata=%h m_tlast=%b expected %h %b",
                             cyc, m_tdata, m_tlast, q[0], exp_last);
                end
            end
            do_pop  = (q.size() != 0) && m_tready;
            do_push = s_tvalid && (q.size() < DEPTH);
            exp_done = do_pop && exp_last;
            stalled  = (q.size() != 0) && !m_tready;
            if (q.size() != 0) held = q[0];
            if (do_pop) begin
                void'(q.pop_front());
                pops++;
                if (exp_last) lasts++;
            end
            if (do_push) q.push_back(s_tdata);
            tick();
            cyc++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        n_tests++;
        if (pops != 1000 || lasts != 1000 / MM_LEN) begin
            n_fail++;
            $display("FAIL rand_totals: pops=%0d lasts=%0d expected 1000 %0d", pops, lasts, 1000 / MM_LEN);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        frame_len = '0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        m_tready  = 1'b0;
        test_reset();
        test_fill_full();
        test_back_to_back();
        test_frame_tlast();
        test_len_one();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_stream_fifo.md
Name: dma_stream_fifo

Overview:
- AXI-stream elastic buffer between the DMA engine's stream master port (ss_tdata/ss_tvalid/ss_tready) and the FIR/matmul accelerator input.
- Decouples Wishbone read bursts from accelerator back-pressure, so the DMA keeps fetching while the engine stalls.
- Generates m_tlast per programmed frame length (taps, data, matrix rows); the DMA itself has no tlast.
- Reports fill level and a frame-done pulse for the DMA sequencer.

Parameters:
- DW, 32, stream data width in bits.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- LENW, 6, width of frame_len and the beat counter.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_n_i  in  1  reset; asynchronous assert, active-low.
- flush_i  in  1  synchronous clear of contents and frame counter.
- frame_len_i  in  LENW  beats per frame; 0 disables tlast.
- s_tdata  in  DW  upstream data from the DMA.
- s_tvalid  in  1  upstream valid.
- s_tready  out  1  upstream ready.
- m_tdata  out  DW  downstream data to the accelerator.
- m_tvalid  out  1  downstream valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  last beat of the current frame.
- level_o  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- frame_done_o  out  1  one-cycle pulse after each tlast handshake.

Behaviour:
- Reset asynchronous and active-low; any mid-operation assertion discards contents immediately.
- Cleared on reset: wr_ptr, rd_ptr, beat_cnt and frame_done_o go to 0.
- Output values during reset: m_tvalid=0, m_tlast=0, level_o=0, s_tready=0 (s_tready is gated low while wb_rst_n_i=0).
- After reset release: s_tready=1.
- Storage: register array, DEPTH x DW.
- Pointers: log2(DEPTH)+1 bits with a wrap bit.
  - empty = (wr_ptr==rd_ptr).
  - full = same index, differing wrap bit.
  - level_o = wr_ptr - rd_ptr, modulo 2^(log2(DEPTH)+1).
- push = s_tvalid & s_tready; pop = m_tvalid & m_tready.
- s_tready = !full & !flush_i. It has no combinational dependence on m_tready, so a pop cannot free space for a same-cycle push when full.
- m_tvalid = !empty; m_tdata = mem[rd_ptr index], first-word fall-through.
- Latency: a word pushed in cycle N is visible on m_tdata/m_tvalid in cycle N+1. Minimum fill-to-drain is 1 cycle.
- Simultaneous push and pop when not full and not empty: level unchanged; both pointers advance.
- Push into an empty FIFO while m_tready=1: no same-cycle bypass; the word is popped in N+1.
- Throughput: one beat per cycle sustained when DEPTH≥2 and both sides are always ready.
- Data ordering: strict FIFO. m_tdata is held stable while m_tvalid=1 and m_tready=0 (AXI-stream rule).
- Frame counter beat_cnt (LENW bits):
  - if frame_len_i≠0: m_tlast = m_tvalid & (beat_cnt == frame_len_i-1).
  - On pop: if m_tlast then beat_cnt←0, else beat_cnt←beat_cnt+1.
  - frame_len_i==0: m_tlast held 0, beat_cnt held 0.
  - frame_len_i==1: tlast on every beat.
- frame_done_o: registered; high for exactly one cycle, the cycle after a pop with m_tlast=1.
- frame_len_i may only change when beat_cnt==0. If changed mid-frame, the comparison uses the new value immediately. beat_cnt ≥ new length does not wrap until the counter wraps at 2^LENW; this is documented, not guarded.
- flush_i=1:
  - Next cycle: wr_ptr=rd_ptr=0, beat_cnt=0, frame_done_o=0.
  - Overrides push and pop that cycle; s_tready=0 that cycle.
  - m_tvalid may still be 1 combinationally; the accelerator must ignore a handshake during flush.
- Full boundary: at level DEPTH, s_tready=0; the DMA must hold s_tdata/s_tvalid.
- Empty boundary: at level 0, m_tvalid=0; m_tdata is don't-care.

Decomposition:
- Shared package (dma_pkg): DW default, DMA_FIFO_DEPTH default, LENW, frame-length constants FIR_TAPS=11, FIR_DATA=64, MM_LEN=32.
- No sub-module: pointer logic, storage and frame counter stay inline. Further splitting only adds ports.

Test Plan:
- Reset: drive wb_rst_n_i low mid-stream with level 5 -> same cycle level_o=0, m_tvalid=0, s_tready=0; after release s_tready=1, no stale data emerges.
- Fill/full: DEPTH=8, m_tready=0, push 0x100..0x108 -> 8 accepted, s_tready=0 at level 8, 0x108 held. Then m_tready=1 -> output 0x100..0x108 in order, one per cycle.
- Streaming: s_tvalid and m_tready both 1 for 64 beats of 1..64 -> level_o stays ≤1 after cycle 1, output count 64, first output one cycle after first push.
- Frame tlast: frame_len_i=11, stream 22 words -> m_tlast on beats 11 and 22 only; frame_done_o pulses on the cycles after those two handshakes.
- Random back-pressure: random s_tvalid/m_tready at 50% for 1000 beats with frame_len_i=32 -> scoreboard matches, m_tdata stable while stalled, tlast every 32nd beat.
- Flush: level 4 with beat_cnt=3, pulse flush_i -> next cycle level_o=0, m_tvalid=0. Next frame of length 11 places tlast on its 11th beat.
